// File: rtl/wlm_pkg.sv
// Shared constants and width helpers for the word-level Montgomery reducer.
package wlm_pkg;

  function automatic int wlm_w(input int logq, input int logqh);
    return logq - logqh;
  endfunction

  function automatic int wlm_l(input int logq, input int logqh);
    int w;
    w = wlm_w(logq, logqh);
    return (logq + w - 1) / w;
  endfunction

  function automatic int wlm_lat(input int logq, input int logqh, input int ff_in,
                                 input int ff_sub, input int ff_mul, input int ff_sum,
                                 input int ff_out);
    return ff_in + wlm_l(logq, logqh) * (ff_sub + ff_mul + ff_sum) + ff_out;
  endfunction

  // width of the qH*m product
  function automatic int wlm_pw(input int logq, input int logqh);
    return logqh + wlm_w(logq, logqh);
  endfunction

  // running-value width entering iteration k (k=0 is C plus a guard bit)
  function automatic int wlm_xw(input int logq, input int logqh, input int k);
    int x, w, pw;
    w  = wlm_w(logq, logqh);
    pw = wlm_pw(logq, logqh);
    x  = 2 * logq + 1;
    for (int i = 0; i < k; i++)
      x = (((x - w) > pw) ? (x - w) : pw) + 1;
    return x;
  endfunction

endpackage

// File: rtl/wlm_reducer_iter.sv
// One word iteration X' = X_H + qH*m + (X_L != 0), m = -X_L mod 2^W, with optional
// FF_SUB/FF_MUL/FF_SUM stages; qH rides along. WLM_MIXED_EN selects the mixed product.
module wlm_iter
  import wlm_pkg::*;
#(
  parameter int LOGQ   = 60,
  parameter int LOGQH  = 17,
  parameter int K      = 0,
  parameter int FF_SUB = 0,
  parameter int FF_MUL = 1,
  parameter int FF_SUM = 0,
  localparam int W  = wlm_w(LOGQ, LOGQH),
  localparam int PW = wlm_pw(LOGQ, LOGQH),
  localparam int IW = wlm_xw(LOGQ, LOGQH, K),
  localparam int OW = wlm_xw(LOGQ, LOGQH, K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    xi,
  input  logic [LOGQH-1:0] qi,
  output logic [OW-1:0]    xo,
  output logic [LOGQH-1:0] qo
);

  localparam int HW = IW - W;

  logic [HW-1:0]    xh_a, xh_b, xh_c;
  logic [W-1:0]     m_a, m_b;
  logic             cy_a, cy_b, ci_b, ci_c;
  logic [LOGQH-1:0] q_b, q_c;
  logic [PW-1:0]    p_b, p_c;
  logic [OW-1:0]    s_c;

  assign xh_a = xi[IW-1:W];
  assign m_a  = -xi[W-1:0];
  assign cy_a = |xi[W-1:0];

  if (FF_SUB != 0) begin : g_sub_ff
    always_ff @(posedge clk) begin
      if (rst) begin
        xh_b <= '0; m_b <= '0; cy_b <= 1'b0; q_b <= '0;
      end else begin
        xh_b <= xh_a; m_b <= m_a; cy_b <= cy_a; q_b <= qi;
      end
    end
  end else begin : g_sub_w
    assign xh_b = xh_a;
    assign m_b  = m_a;
    assign cy_b = cy_a;
    assign q_b  = qi;
  end

`ifdef WLM_MIXED_EN
  // native LOGQH x W partial product; the +carry shares its accumulate adder
  logic [PW-1:0] pp;
  assign pp   = PW'(q_b) * PW'(m_b);
  assign p_b  = pp + PW'(cy_b);
  assign ci_b = 1'b0;
`else
  assign p_b  = PW'(q_b) * PW'(m_b);
  assign ci_b = cy_b;
`endif

  if (FF_MUL != 0) begin : g_mul_ff
    always_ff @(posedge clk) begin
      if (rst) begin
        xh_c <= '0; p_c <= '0; ci_c <= 1'b0; q_c <= '0;
      end else begin
        xh_c <= xh_b; p_c <= p_b; ci_c <= ci_b; q_c <= q_b;
      end
    end
  end else begin : g_mul_w
    assign xh_c = xh_b;
    assign p_c  = p_b;
    assign ci_c = ci_b;
    assign q_c  = q_b;
  end

  assign s_c = OW'(xh_c) + OW'(p_c) + OW'(ci_c);

  if (FF_SUM != 0) begin : g_sum_ff
    always_ff @(posedge clk) begin
      if (rst) begin
        xo <= '0; qo <= '0;
      end else begin
        xo <= s_c; qo <= q_c;
      end
    end
  end else begin : g_sum_w
    assign xo = s_c;
    assign qo = q_c;
  end

endmodule

// File: rtl/wlm_reducer.sv
// Pipelined word-level Montgomery reduction T = C*2^(-W*L) mod q, q = qH*2^W + 1.
// Optional macro WLM_MIXED_EN: mixed qH*m product and an extra wlm_reducer_mixed wrapper.
module wlm_reducer
  import wlm_pkg::*;
#(
  parameter int LOGQ    = 60,
  parameter int LOGQH   = 17,
  parameter int CORRECT = 1,
  parameter int FF_IN   = 1,
  parameter int FF_SUB  = 0,
  parameter int FF_MUL  = 1,
  parameter int FF_SUM  = 0,
  parameter int FF_OUT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LOGQH-1:0]    qH,
  input  logic [2*LOGQ-1:0]   C,
  output logic [LOGQ-1:0]     T
);

  localparam int W   = wlm_w(LOGQ, LOGQH);
  localparam int L   = wlm_l(LOGQ, LOGQH);
  localparam int LAT = wlm_lat(LOGQ, LOGQH, FF_IN, FF_SUB, FF_MUL, FF_SUM, FF_OUT);
  localparam int XW  = wlm_xw(LOGQ, LOGQH, L);

  logic [2*LOGQ-1:0] c_s;
  logic [LOGQH-1:0]  qh_s;

  if (FF_IN != 0) begin : g_in_ff
    always_ff @(posedge clk) begin
      if (rst) begin
        c_s <= '0; qh_s <= '0;
      end else begin
        c_s <= C; qh_s <= qH;
      end
    end
  end else begin : g_in_w
    assign c_s  = C;
    assign qh_s = qH;
  end

  for (genvar k = 0; k < L; k++) begin : g_it
    localparam int IW = wlm_xw(LOGQ, LOGQH, k);
    localparam int OW = wlm_xw(LOGQ, LOGQH, k + 1);
    logic [IW-1:0]    xi;
    logic [LOGQH-1:0] qi;
    logic [OW-1:0]    xo;
    logic [LOGQH-1:0] qo;

    if (k == 0) begin : g_first
      assign xi = {1'b0, c_s};
      assign qi = qh_s;
    end else begin : g_next
      assign xi = g_it[k-1].xo;
      assign qi = g_it[k-1].qo;
    end

    wlm_iter #(
      .LOGQ(LOGQ), .LOGQH(LOGQH), .K(k),
      .FF_SUB(FF_SUB), .FF_MUL(FF_MUL), .FF_SUM(FF_SUM)
    ) u_iter (
      .clk(clk), .rst(rst), .xi(xi), .qi(qi), .xo(xo), .qo(qo)
    );
  end

  logic [XW-1:0]    xf;
  logic [LOGQH-1:0] qhf;
  logic [LOGQ-1:0]  t_c;

  assign xf  = g_it[L-1].xo;
  assign qhf = g_it[L-1].qo;

  // X < 2q here, so one conditional subtract lands in [0, q)
  if (CORRECT != 0) begin : g_corr
    logic [XW-1:0] qf;
    assign qf  = (XW'(qhf) << W) | XW'(1);
    assign t_c = (xf >= qf) ? LOGQ'(xf - qf) : LOGQ'(xf);
  end else begin : g_lazy
    assign t_c = LOGQ'(xf);
  end

  if (FF_OUT != 0) begin : g_out_ff
    always_ff @(posedge clk) begin
      if (rst) T <= '0;
      else     T <= t_c;
    end
  end else begin : g_out_w
    assign T = t_c;
  end

endmodule

`ifdef WLM_MIXED_EN
module wlm_reducer_mixed
  import wlm_pkg::*;
#(
  parameter int LOGQ    = 60,
  parameter int LOGQH   = 17,
  parameter int CORRECT = 1,
  parameter int FF_IN   = 1,
  parameter int FF_SUB  = 0,
  parameter int FF_MUL  = 1,
  parameter int FF_SUM  = 0,
  parameter int FF_OUT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LOGQH-1:0]    qH,
  input  logic [2*LOGQ-1:0]   C,
  output logic [LOGQ-1:0]     T
);
  localparam int LAT = wlm_lat(LOGQ, LOGQH, FF_IN, FF_SUB, FF_MUL, FF_SUM, FF_OUT);

  wlm_reducer #(
    .LOGQ(LOGQ), .LOGQH(LOGQH), .CORRECT(CORRECT), .FF_IN(FF_IN),
    .FF_SUB(FF_SUB), .FF_MUL(FF_MUL), .FF_SUM(FF_SUM), .FF_OUT(FF_OUT)
  ) u_core (
    .clk(clk), .rst(rst), .qH(qH), .C(C), .T(T)
  );
endmodule
`endif

// File: tb/tb_wlm_reducer.sv
// Scoreboard bench: drives C/qH every cycle, reference model uses modular halving.
module tb_wlm_reducer;
  localparam int LOGQ = 60, LOGQH = 17, W = 43, RB = 86, LAT = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [LOGQH-1:0]    qH = '0;
  logic [2*LOGQ-1:0]   C = '0;
  logic [LOGQ-1:0]     T, T0;

  always #5 clk = ~clk;

  wlm_reducer #(.LOGQ(LOGQ), .LOGQH(LOGQH), .CORRECT(1)) dut (
    .clk(clk), .rst(rst), .qH(qH), .C(C), .T(T));
  wlm_reducer #(.LOGQ(LOGQ), .LOGQH(LOGQH), .CORRECT(0)) dut0 (
    .clk(clk), .rst(rst), .qH(qH), .C(C), .T(T0));

  typedef struct {
    int           cyc;
    logic [127:0] e;
    logic [127:0] q;
    bit           chk0;
    bit           zr;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [127:0] qof(input logic [LOGQH-1:0] h);
    logic [127:0] hv;
    hv = 128'(h);
    return (hv << W) + 128'd1;
  endfunction

  // C * 2^-86 mod q: reduce, then halve modulo q 86 times
  function automatic logic [127:0] golden(input logic [127:0] c, input logic [127:0] q);
    logic [127:0] x;
    x = c % q;
    for (int i = 0; i < RB; i++)
      x = x[0] ? ((x + q) >> 1) : (x >> 1);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ent_t         en;
    logic [127:0] r;
    if (rst_q) begin
      chk("reset_T", 128'(T), 128'd0);
      chk("reset_T_lazy", 128'(T0), 128'd0);
    end
    while (sb.size() > 0 && sb[0].cyc + LAT - 1 <= cyc) begin
      en = sb.pop_front();
      if (en.cyc + LAT - 1 < cyc) begin
        errors++;
        $display("FAIL stale entry for edge %0d seen at cycle %0d", en.cyc, cyc);
      end else begin
        chk("T", 128'(T), en.e);
        if (en.zr)
          chk("T_lazy_zero", 128'(T0), 128'd0);
        else if (en.chk0) begin
          r = 128'(T0) % en.q;
          chk("T_lazy_mod", r, en.e);
          chk("T_lazy_lt2q", {127'd0, (128'(T0) < 2 * en.q)}, 128'd1);
        end
      end
    end
  end

  task automatic drive(input logic [127:0] c, input logic [LOGQH-1:0] h,
                       input bit use_gold, input logic [127:0] ex);
    ent_t en;
    @(negedge clk);
    rst = 1'b0;
    C   = c[2*LOGQ-1:0];
    qH  = h;
    en.cyc  = cyc + 1;
    en.q    = qof(h);
    en.e    = use_gold ? golden(c, en.q) : ex;
    en.chk0 = (h <= 17'h0FFFF);
    en.zr   = 1'b0;
    sb.push_back(en);
  endtask

  task automatic rand_op(input logic [LOGQH-1:0] hmax);
    logic [LOGQH-1:0] h;
    logic [127:0]     q, c;
    h = LOGQH'($urandom_range(0, int'(hmax)));
    q = qof(h);
    c = {$urandom(), $urandom(), $urandom(), $urandom()} % (q * q);
    drive(c, h, 1'b1, 128'd0);
  endtask

  // one-cycle reset mid-stream; everything still in flight must come out as 0
  task automatic do_reset();
    ent_t en;
    @(negedge clk);
    rst = 1'b1;
    C   = {$urandom(), $urandom(), $urandom(), $urandom()};
    qH  = LOGQH'($urandom());
    foreach (sb[i])
      if (sb[i].cyc + LAT - 1 > cyc) begin
        sb[i].e  = '0;
        sb[i].zr = 1'b1;
      end
    en.cyc = cyc + 1; en.q = qof(qH); en.e = '0; en.chk0 = 1'b0; en.zr = 1'b1;
    sb.push_back(en);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] q1;
    q1 = qof(17'h1FFFF);
    repeat (3) @(negedge clk);
    repeat (6) drive(128'd0, 17'h1FFFF, 1'b0, 128'd0);
    drive(128'd1 << RB, 17'h1FFFF, 1'b0, 128'd1);
    drive(128'd5 << RB, 17'h1FFFF, 1'b0, 128'd5);
    drive(q1, 17'h1FFFF, 1'b0, 128'd0);
    drive(q1 << 40, 17'h1FFFF, 1'b0, 128'd0);
    for (int k = 1; k <= 8; k++)
      drive(128'(k) << RB, 17'h1FFFF, 1'b0, 128'(k));
    repeat (20) rand_op(17'h1FFFF);
    do_reset();
    repeat (20) rand_op(17'h1FFFF);
    repeat (40) rand_op(17'h0FFFF);
    repeat (LAT + 2) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never checked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
